// File: rtl/mul3_pkg.sv
// Shared state encoding, default widths and the accumulator add helper
// for the mul3 result accumulator.
package mul3_pkg;

    localparam int unsigned PW_DEF    = 14;
    localparam int unsigned ACC_W_DEF = 24;
    localparam int unsigned CW_DEF    = 8;

    // Widest accumulator the add helper supports.
    localparam int unsigned ADD_MAX_W = 64;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ACC  = ST_ACC,
        DONE = ST_DONE
    } state_e;

    typedef struct packed {
        logic                 carry;
        logic [ADD_MAX_W-1:0] sum;
    } add_res_t;

    // Adds two operands that both fit in w bits. carry reports an overflow out
    // of w bits; sum is truncated to w bits, or pinned at 2^w-1 when sat is set.
    function automatic add_res_t sat_add(
        input logic [ADD_MAX_W-1:0] a,
        input logic [ADD_MAX_W-1:0] b,
        input int unsigned          w,
        input logic                 sat
    );
        logic [ADD_MAX_W:0]   full;
        logic [ADD_MAX_W-1:0] mask;
        add_res_t             r;
        full    = {1'b0, a} + {1'b0, b};
        mask    = (ADD_MAX_W'(1) << w) - ADD_MAX_W'(1);
        r.carry = |(full & ~{1'b0, mask});
        r.sum   = full[ADD_MAX_W-1:0] & mask;
        if (sat && r.carry) begin
            r.sum = mask;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul3_result_acc_if.sv
// Handshake bundle between the product source, the accumulator and the
// result consumer.
interface mul3_result_acc_if
    import mul3_pkg::*;
#(
    parameter int unsigned PW    = PW_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CW    = CW_DEF
);

    logic             start;
    logic [CW-1:0]    len;
    logic [PW-1:0]    p_in;
    logic             in_valid;
    logic             in_ready;
    logic             out_ready;
    logic             out_valid;
    logic [ACC_W-1:0] sum_out;
    logic [PW-1:0]    max_out;
    logic [CW-1:0]    cnt_out;
    logic             ovf;

    modport master (
        output start, len, p_in, in_valid, out_ready,
        input  in_ready, out_valid, sum_out, max_out, cnt_out, ovf
    );

    modport slave (
        input  start, len, p_in, in_valid, out_ready,
        output in_ready, out_valid, sum_out, max_out, cnt_out, ovf
    );

endinterface

// File: rtl/mul3_result_acc_dp.sv
// Accumulator datapath: running sum, maximum, sample count and sticky overflow.
// Define MUL3_ACC_SAT_EN to saturate the sum instead of wrapping it.
module mul3_acc_dp
    import mul3_pkg::*;
#(
    parameter int unsigned PW    = PW_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CW    = CW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             acc_en,
    input  logic [PW-1:0]    p_in,
    output logic [ACC_W-1:0] sum_q,
    output logic [PW-1:0]    max_q,
    output logic [CW-1:0]    cnt_q,
    output logic             ovf_q
);

`ifdef MUL3_ACC_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic [ACC_W-1:0] sum_d;
    logic [PW-1:0]    max_d;
    logic [CW-1:0]    cnt_d;
    logic             ovf_d;
    add_res_t         add_r;
    logic             unused_add_hi;

    assign add_r         = sat_add(ADD_MAX_W'(sum_q), ADD_MAX_W'(p_in), ACC_W, SAT_EN);
    assign unused_add_hi = ^(add_r.sum >> ACC_W);

    always_comb begin
        sum_d = sum_q;
        max_d = max_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            sum_d = '0;
            max_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (acc_en) begin
            // A saturated sum stays pinned: any further non-zero add carries again.
            sum_d = add_r.sum[ACC_W-1:0];
            cnt_d = cnt_q + CW'(1);
            ovf_d = ovf_q | add_r.carry;
            if (p_in > max_q) begin
                max_d = p_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            max_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            max_q <= max_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: rtl/mul3_result_acc.sv
// Reduces a run of multiplier products to sum/max/count/overflow statistics.
// Define MUL3_ACC_SAT_EN to saturate the sum instead of wrapping it.
module mul3_result_acc
    import mul3_pkg::*;
#(
    parameter int unsigned PW    = PW_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CW    = CW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    mul3_result_acc_if.slave bus
);

    state_e        state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          clr;
    logic          acc_en;

    logic [ACC_W-1:0] sum_q;
    logic [PW-1:0]    max_q;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        clr     = 1'b0;
        acc_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && (bus.len != '0)) begin
                    len_d   = bus.len;
                    clr     = 1'b1;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (bus.in_valid && in_ready_q) begin
                    acc_en = 1'b1;
                    if ((cnt_q + CW'(1)) == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered copies of the next-state decode.
        in_ready_d  = (state_d == ACC);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    mul3_acc_dp #(
        .PW    (PW),
        .ACC_W (ACC_W),
        .CW    (CW)
    ) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .acc_en (acc_en),
        .p_in   (bus.p_in),
        .sum_q  (sum_q),
        .max_q  (max_q),
        .cnt_q  (cnt_q),
        .ovf_q  (ovf_q)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum_out   = sum_q;
    assign bus.max_out   = max_q;
    assign bus.cnt_out   = cnt_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mul3_result_acc.sv
// Scoreboard bench for mul3_result_acc: directed runs plus random runs checked
// against an arithmetic reference model.
module tb_mul3_result_acc;

    localparam int unsigned PW    = 14;
    localparam int unsigned ACC_W = 16;
    localparam int unsigned CW    = 8;
    localparam longint      ACC_MAX = (longint'(1) << ACC_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mul3_result_acc_if #(.PW(PW), .ACC_W(ACC_W), .CW(CW)) bus ();

    mul3_result_acc #(.PW(PW), .ACC_W(ACC_W), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        longint sum;
        longint mx;
        longint cnt;
        longint ovf;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    bit          have = 1'b0;
    int          total = 0;
    int          bad   = 0;
    int unsigned prods[$];

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: exact total, then wrap or clamp at the accumulator width.
    function automatic exp_t model(input int unsigned p[$]);
        exp_t   e;
        longint t = 0;
        longint m = 0;
        foreach (p[i]) begin
            t += p[i];
            if (p[i] > m) m = p[i];
        end
        e.cnt = p.size();
        e.mx  = m;
        e.ovf = (t > ACC_MAX) ? 1 : 0;
`ifdef MUL3_ACC_SAT_EN
        e.sum = (t > ACC_MAX) ? ACC_MAX : t;
`else
        e.sum = t % (ACC_MAX + 1);
`endif
        return e;
    endfunction

    // Monitor: pops one expectation per result presentation and checks every
    // cycle that out_valid is held.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n || !bus.out_valid) begin
                have = 1'b0;
            end else begin
                if (!have) begin
                    check("result_expected", (exp_q.size() != 0) ? 1 : 0, 1);
                    if (exp_q.size() != 0) begin
                        cur  = exp_q.pop_front();
                        have = 1'b1;
                    end
                end
                if (have) begin
                    check("sum_out", bus.sum_out, cur.sum);
                    check("max_out", bus.max_out, cur.mx);
                    check("cnt_out", bus.cnt_out, cur.cnt);
                    check("ovf", bus.ovf, cur.ovf);
                    check("in_ready_in_done", bus.in_ready, 0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int unsigned l);
        bus.start = 1'b1;
        bus.len   = CW'(l);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input int unsigned p, input int unsigned gap);
        int unsigned budget = 0;
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.p_in     = PW'(p);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && budget < 50) begin
            tick();
            budget++;
        end
        check("in_ready_before_accept", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic run(input int unsigned gap_lo, input int unsigned gap_hi,
                       input int unsigned hold, input bit mid_start, input bit start_at_hs);
        exp_t        e = model(prods);
        int unsigned n = prods.size();
        exp_q.push_back(e);
        bus.out_ready = 1'b0;
        pulse_start(n);
        foreach (prods[i]) begin
            if (mid_start && i == 1) begin
                bus.start = 1'b1;
                bus.len   = CW'(1);
                tick();
                bus.start = 1'b0;
            end
            send(prods[i], $urandom_range(gap_hi, gap_lo));
        end
        check("out_valid_latency", bus.out_valid, 1);
        check("in_ready_after_last", bus.in_ready, 0);
        repeat (hold) tick();
        bus.out_ready = 1'b1;
        if (start_at_hs) begin
            bus.start = 1'b1;
            bus.len   = CW'(2);
        end
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check("out_valid_cleared", bus.out_valid, 0);
        tick();
        check("idle_in_ready", bus.in_ready, 0);
        check("idle_out_valid", bus.out_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_sum"}, bus.sum_out, 0);
        check({tag, "_max"}, bus.max_out, 0);
        check({tag, "_cnt"}, bus.cnt_out, 0);
        check({tag, "_ovf"}, bus.ovf, 0);
    endtask

    initial begin
        int unsigned n;
        int unsigned budget;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.p_in      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Product offered while idle must not be taken.
        bus.in_valid = 1'b1;
        bus.p_in     = PW'(99);
        repeat (3) tick();
        check("idle_no_transfer_cnt", bus.cnt_out, 0);
        check("idle_no_transfer_sum", bus.sum_out, 0);
        check("idle_in_ready_low", bus.in_ready, 0);
        bus.in_valid = 1'b0;

        // Zero-length start is ignored.
        pulse_start(0);
        tick();
        check("len0_in_ready", bus.in_ready, 0);
        check("len0_out_valid", bus.out_valid, 0);

        prods = '{4, 18, 48};
        run(0, 0, 0, 1'b0, 1'b0);
        prods = '{4, 18, 48};
        run(2, 2, 0, 1'b0, 1'b0);
        prods = '{4, 18, 48};
        run(0, 0, 5, 1'b0, 1'b0);
        prods = '{16383, 16383, 16383, 16383, 16383};
        run(0, 0, 1, 1'b0, 1'b0);
        prods = '{7, 300, 2};
        run(0, 1, 0, 1'b1, 1'b0);
        prods = '{1000, 16383, 5, 9000};
        run(0, 1, 2, 1'b0, 1'b1);

        // Reset in the middle of a run discards it.
        pulse_start(4);
        send(11, 0);
        send(22, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_all_zero("after_release");
        prods = '{210};
        run(0, 0, 0, 1'b0, 1'b0);

        repeat (20) begin
            n = $urandom_range(12, 1);
            prods.delete();
            repeat (n) prods.push_back($urandom_range(16383, 0));
            run(0, 2, $urandom_range(3, 0), 1'b0, 1'b0);
        end
        repeat (3) begin
            n = $urandom_range(40, 5);
            prods.delete();
            repeat (n) prods.push_back($urandom_range(16383, 12000));
            run(0, 1, $urandom_range(2, 0), 1'b0, 1'b0);
        end

        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            tick();
            budget++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
